// File: rtl/conv_sequencer_if.sv
// Bus between the convolution sequencer and its operand/result
// memories and the accumulating MAC.
interface conv_sequencer_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int Z_W    = 16
);
   logic              start;
   logic [ADDR_W-1:0] len_x;
   logic [ADDR_W-1:0] len_y;
   logic [ADDR_W-1:0] x_addr;
   logic [DATA_W-1:0] x_data;
   logic [ADDR_W-1:0] y_addr;
   logic [DATA_W-1:0] y_data;
   logic [DATA_W-1:0] mac_x;
   logic [DATA_W-1:0] mac_y;
   logic              mac_load;
   logic              mac_clr_n;
   logic [Z_W-1:0]    mac_z;
   logic [ADDR_W:0]   z_addr;
   logic [Z_W-1:0]    z_data;
   logic              z_we;
   logic              busy;
   logic              done;

   modport master (
      input  start, len_x, len_y,
      input  x_data, y_data, mac_z,
      output x_addr, y_addr,
      output mac_x, mac_y,
      output mac_load, mac_clr_n,
      output z_addr, z_data, z_we,
      output busy, done
   );

   modport slave (
      output start, len_x, len_y,
      output x_data, y_data, mac_z,
      input  x_addr, y_addr,
      input  mac_x, mac_y,
      input  mac_load, mac_clr_n,
      input  z_addr, z_data, z_we,
      input  busy, done
   );
endinterface

// File: rtl/conv_sequencer.sv
// Walks z[n] = sum_k x[k]*y[n-k] over sync-read operand RAMs,
// driving the MAC and writing each finished z[n] to the result RAM.
module conv_sequencer #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int Z_W    = 16
) (
   input logic               clk,
   input logic               rst,
   conv_sequencer_if.master  bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]        state;
   logic [ADDR_W-1:0] lx;
   logic [ADDR_W-1:0] ly;
   logic [ADDR_W:0]   n;
   logic [ADDR_W-1:0] kmax;
   logic [ADDR_W-1:0] x_addr_q;
   logic [ADDR_W-1:0] y_addr_q;
   logic              mac_load_q;
   logic              mac_clr_n_q;
   logic              busy_q;
   logic              done_q;

   logic [ADDR_W:0]   n_last;
   logic [ADDR_W-1:0] kmin_w;
   logic [ADDR_W-1:0] kmax_w;
   logic [ADDR_W-1:0] y0_w;

   // True results fit in ADDR_W bits, so modular subtraction is exact.
   always_comb begin
      n_last = {1'b0, lx} + {1'b0, ly};
      kmin_w = '0;
      if (n > {1'b0, ly})
         kmin_w = n[ADDR_W-1:0] - ly;
      kmax_w = lx;
      if (n < {1'b0, lx})
         kmax_w = n[ADDR_W-1:0];
      y0_w = n[ADDR_W-1:0] - kmin_w;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         lx          <= '0;
         ly          <= '0;
         n           <= '0;
         kmax        <= '0;
         x_addr_q    <= '0;
         y_addr_q    <= '0;
         mac_load_q  <= 1'b0;
         mac_clr_n_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         mac_load_q <= (state == S_ISSUE);
         done_q     <= 1'b0;
         unique case (1'b1)
            (state == S_IDLE): begin
               mac_clr_n_q <= 1'b1;
               if (bus.start) begin
                  lx          <= bus.len_x;
                  ly          <= bus.len_y;
                  n           <= '0;
                  busy_q      <= 1'b1;
                  mac_clr_n_q <= 1'b0;
                  state       <= S_CLEAR;
               end
            end
            (state == S_CLEAR): begin
               mac_clr_n_q <= 1'b1;
               x_addr_q    <= kmin_w;
               y_addr_q    <= y0_w;
               kmax        <= kmax_w;
               state       <= S_ISSUE;
            end
            (state == S_ISSUE): begin
               if (x_addr_q == kmax) begin
                  state <= S_DRAIN;
               end else begin
                  x_addr_q <= x_addr_q + 1'b1;
                  y_addr_q <= y_addr_q - 1'b1;
               end
            end
            (state == S_DRAIN): begin
               state <= S_WRITE;
            end
            (state == S_WRITE): begin
               if (n == n_last) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= S_DONE;
               end else begin
                  n           <= n + 1'b1;
                  mac_clr_n_q <= 1'b0;
                  state       <= S_CLEAR;
               end
            end
            (state == S_DONE): begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.x_addr    = x_addr_q;
   assign bus.y_addr    = y_addr_q;
   assign bus.mac_x     = bus.x_data;
   assign bus.mac_y     = bus.y_data;
   assign bus.mac_load  = mac_load_q;
   assign bus.mac_clr_n = mac_clr_n_q;
   assign bus.z_we      = (state == S_WRITE);
   assign bus.z_addr    = n;
   assign bus.z_data    = (state == S_WRITE) ? bus.mac_z : '0;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
endmodule
